// File: rtl/sram_port_arbiter.sv
// Single-port pixel SRAM arbiter: the CCD write stream and the homography reads share one
// access per cycle. Read-to-write switches get a turnaround cycle, and write starvation is bounded.
module sram_port_arbiter #(
  parameter int unsigned FRAME_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT  = 480,
  parameter int unsigned RD_LATENCY    = 2,
  parameter int unsigned WR_STARVE_MAX = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iWR_Valid,
  input  logic [9:0]  iWR_X,
  input  logic [9:0]  iWR_Y,
  input  logic [15:0] iWR_Data,
  output logic        oWR_Ready,
  input  logic        iRD_Req,
  input  logic [9:0]  iRD_X,
  input  logic [9:0]  iRD_Y,
  output logic        oRD_Ack,
  output logic        oRD_Valid,
  output logic [15:0] oRD_Data,
  output logic [19:0] oSRAM_ADDR,
  output logic        oSRAM_WE,
  output logic        oSRAM_DQ_OE,
  output logic [15:0] oSRAM_DQ_OUT,
  input  logic [15:0] iSRAM_DQ_IN,
  output logic        oRangeErr
);

  localparam int unsigned     SW         = $clog2(WR_STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(WR_STARVE_MAX);
  localparam logic [19:0]     FW20       = 20'(FRAME_WIDTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_TURN} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          starve_q, starve_d;
  logic [19:0]            addr_q, addr_d;
  logic                   we_q, we_d;
  logic                   oe_q, oe_d;
  logic [15:0]            dq_out_q, dq_out_d;
  logic                   range_err_q, range_err_d;
  logic [RD_LATENCY-1:0]  tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0]  tag_oor_q, tag_oor_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [15:0]            rd_data_q, rd_data_d;

  logic        wr_oor, rd_oor, rd_elig, wr_elig, wr_grant, rd_grant;
  logic [19:0] wr_addr, rd_addr;

  always_comb begin
    wr_oor   = (32'(iWR_X) >= FRAME_WIDTH) || (32'(iWR_Y) >= FRAME_HEIGHT);
    rd_oor   = (32'(iRD_X) >= FRAME_WIDTH) || (32'(iRD_Y) >= FRAME_HEIGHT);
    wr_addr  = 20'(iWR_Y) * FW20 + 20'(iWR_X);
    rd_addr  = 20'(iRD_Y) * FW20 + 20'(iRD_X);
    // A write straight after a read grant would collide with the bus turnaround.
    rd_elig  = iRD_Req && (starve_q < STARVE_LIM) && !iRST;
    wr_elig  = iWR_Valid && (state_q != ST_READ) && !iRST;
    rd_grant = rd_elig;
    wr_grant = wr_elig && !rd_elig;

    state_d     = ST_IDLE;
    starve_d    = '0;
    addr_d      = addr_q;
    we_d        = 1'b0;
    oe_d        = 1'b0;
    dq_out_d    = dq_out_q;
    range_err_d = range_err_q;

    if (rd_grant) begin
      state_d = ST_READ;
      if (rd_oor) range_err_d = 1'b1;
      else        addr_d      = rd_addr;
    end else if (wr_grant) begin
      state_d = ST_WRITE;
      if (wr_oor) begin
        range_err_d = 1'b1;
      end else begin
        addr_d   = wr_addr;
        dq_out_d = iWR_Data;
        we_d     = 1'b1;
        oe_d     = 1'b1;
      end
    end else if (iWR_Valid && (state_q == ST_READ)) begin
      state_d = ST_TURN;
    end

    if (iWR_Valid && !wr_grant)
      starve_d = (starve_q >= STARVE_LIM) ? starve_q : starve_q + SW'(1);

    tag_vld_d    = tag_vld_q;
    tag_oor_d    = tag_oor_q;
    tag_vld_d[0] = rd_grant;
    tag_oor_d[0] = rd_oor;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_oor_d[i] = tag_oor_q[i-1];
    end

    rd_valid_d = tag_vld_q[RD_LATENCY-1];
    rd_data_d  = rd_data_q;
    if (rd_valid_d)
      rd_data_d = tag_oor_q[RD_LATENCY-1] ? '0 : iSRAM_DQ_IN;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      dq_out_q    <= '0;
      range_err_q <= 1'b0;
      tag_vld_q   <= '0;
      tag_oor_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      dq_out_q    <= dq_out_d;
      range_err_q <= range_err_d;
      tag_vld_q   <= tag_vld_d;
      tag_oor_q   <= tag_oor_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign oWR_Ready    = wr_grant;
  assign oRD_Ack      = rd_grant;
  assign oRD_Valid    = rd_valid_q;
  assign oRD_Data     = rd_data_q;
  assign oSRAM_ADDR   = addr_q;
  assign oSRAM_WE     = we_q;
  assign oSRAM_DQ_OE  = oe_q;
  assign oSRAM_DQ_OUT = dq_out_q;
  assign oRangeErr    = range_err_q;

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates the single-port pixel SRAM between the CCD write stream (pixels popped from the CCD FIFO) and the homography read requester. It computes linear frame addresses and grants one SRAM access per cycle. It inserts a bus-turnaround cycle on read-to-write switches, bounds write starvation, and returns read data with fixed latency. It sits between the CCD FIFO, the homography engine and the top-level SRAM tristate pads.

## Interface
- FRAME_WIDTH, 640, pixels per line; address = Y*FRAME_WIDTH + X
- FRAME_HEIGHT, 480, lines per frame; used for range checks only
- RD_LATENCY, 2, cycles from address presentation to valid iSRAM_DQ_IN (≥1)
- WR_STARVE_MAX, 4, max consecutive cycles a pending write may be denied (≥1)

Ports:
- iCLK  in  1  system clock; the block uses one clock domain
- iRST  in  1  reset; synchronous and active-high
- iWR_Valid  in  1  CCD FIFO not empty (a write is pending)
- iWR_X  in  10  write pixel X
- iWR_Y  in  10  write pixel Y
- iWR_Data  in  16  RGB565 write pixel
- oWR_Ready  out  1  combinational pop/accept, same cycle as grant
- iRD_Req  in  1  homography read request (level)
- iRD_X  in  10  read pixel X
- iRD_Y  in  10  read pixel Y
- oRD_Ack  out  1  combinational read accept
- oRD_Valid  out  1  one-cycle read-data strobe
- oRD_Data  out  16  read pixel, RGB565
- oSRAM_ADDR  out  20  registered SRAM address
- oSRAM_WE  out  1  registered, 1 = write cycle
- oSRAM_DQ_OE  out  1  registered, 1 = drive DQ pads with oSRAM_DQ_OUT
- oSRAM_DQ_OUT  out  16  registered write data
- iSRAM_DQ_IN  in  16  DQ pad input
- oRangeErr  out  1  sticky; set on any out-of-range coordinate

## Operation
- State machine (last granted op): IDLE, WRITE, READ, TURN. One grant per cycle at most.
- Grant rules, evaluated each cycle:
  - Reads are blocked when starve_cnt ≥ WR_STARVE_MAX.
  - A write is blocked when the previous cycle's grant was a read. That cycle is TURN: no grant, and both accepts are low.
  - If both requests are eligible, the read wins.
  - Otherwise the sole eligible request wins. With none eligible, the next state is IDLE.
- starve_cnt is saturating. It increments in each cycle where iWR_Valid=1 and the write is not granted, including TURN cycles. It clears on a write grant or when iWR_Valid=0.
- Write grant: oWR_Ready=1. The next cycle drives oSRAM_ADDR = address, oSRAM_DQ_OUT = iWR_Data, oSRAM_WE=1, oSRAM_DQ_OE=1.
- Read grant: oRD_Ack=1. The next cycle drives oSRAM_ADDR = address, oSRAM_WE=0, oSRAM_DQ_OE=0. A tag enters an RD_LATENCY-deep shift pipeline.
- Reads are fully pipelined; a new read may be accepted every cycle.
- Idle/TURN SRAM cycle: WE=0, OE=0; ADDR and DQ_OUT hold their previous values.
- Address arithmetic: Y*FRAME_WIDTH+X, computed at 20 bits. The maximum is 307199, so no overflow occurs.
- Out of range (X≥FRAME_WIDTH or Y≥FRAME_HEIGHT):
  - The request is still accepted and oRangeErr is set.
  - A write is dropped: the SRAM cycle is idle.
  - A read performs no SRAM access but still returns oRD_Data=0 with normal latency.
- Write→read switches need no gap. Read→write switches always cost exactly one TURN cycle.

## Timing
- Reset: all registered outputs are 0 the cycle after the iRST edge. oWR_Ready and oRD_Ack are forced 0 while iRST=1.
- Reset mid-operation: the read pipeline is flushed, with no oRD_Valid for in-flight reads. State returns to IDLE and starve_cnt clears.
- Write: grant in cycle N; SRAM write cycle in N+1.
- Read: ack in cycle N; address in N+1; iSRAM_DQ_IN is sampled at the end of cycle N+RD_LATENCY.
- Read data: oRD_Valid=1 and oRD_Data are valid in cycle N+RD_LATENCY+1, for exactly one cycle. Read order is preserved.
- Starvation bound: a pending write is granted within WR_STARVE_MAX+1 cycles of iWR_Valid rising.
- Simultaneous iWR_Valid and iRD_Req with starve_cnt < max: the read is granted.

## Test plan
- Write X=5, Y=2, data 0xABCD from IDLE:
  - oWR_Ready=1 in cycle N.
  - In N+1: ADDR=1285, WE=1, OE=1, DQ_OUT=0xABCD.
  - In N+2: WE=0, OE=0.
- Read X=639, Y=479, with the SRAM model returning 0x1234 (RD_LATENCY=2):
  - oRD_Ack in N; ADDR=307199 in N+1.
  - oRD_Valid=1 with 0x1234 in N+3 only.
- iRD_Req and iWR_Valid both held high (WR_STARVE_MAX=4):
  - Reads are acked in cycles 1–4 and cycle 5 is TURN.
  - The write is granted in cycle 6 and reads resume in cycle 7 with no gap.
  - The pattern repeats.
- Four back-to-back reads with returned values 1, 2, 3, 4:
  - oRD_Valid is high for four consecutive cycles carrying 1, 2, 3, 4 in order.
  - A following write is preceded by one WE=0/OE=0 cycle.
- Out-of-range coordinates:
  - Write with X=640: oWR_Ready pulses, there is no WE cycle, and oRangeErr=1 stays set.
  - Read with Y=480: oRD_Valid with data 0 at N+3.
- Assert iRST for one cycle with two reads in flight and a write pending:
  - No oRD_Valid follows.
  - All outputs are 0 the next cycle.
  - The write is regranted once iRST=0.
